dvi_timing_gen: RTL and testbench

//  Raster timing source feeding the three per-channel TMDS encoders. Generates pixel

---
 rtl/dvi_pkg.sv | 52 +++++
 rtl/video_delay.sv | 42 ++++
 rtl/dvi_timing_gen.sv | 152 +++++++++++++++
 tb/tb_dvi_timing_gen.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dvi_pkg.sv
// Shared DVI raster definitions: timing descriptor, standard video modes and
// the four TMDS control-period code words.
package dvi_pkg;

    localparam int unsigned CNT_W     = 12;
    localparam int unsigned MAX_TOTAL = 4096;
    localparam int unsigned MAX_DLY   = 15;

    // One raster mode: horizontal/vertical segments in active, fp, sync, bp order.
    typedef struct packed {
        logic [CNT_W-1:0] h_active;
        logic [CNT_W-1:0] h_fp;
        logic [CNT_W-1:0] h_sync;
        logic [CNT_W-1:0] h_bp;
        logic [CNT_W-1:0] v_active;
        logic [CNT_W-1:0] v_fp;
        logic [CNT_W-1:0] v_sync;
        logic [CNT_W-1:0] v_bp;
        logic             hs_pol;
        logic             vs_pol;
    } timing_t;

    localparam timing_t TIMING_640X480_60 = '{
        h_active: 12'd640, h_fp: 12'd16, h_sync: 12'd96, h_bp: 12'd48,
        v_active: 12'd480, v_fp: 12'd10, v_sync: 12'd2,  v_bp: 12'd33,
        hs_pol:   1'b0,    vs_pol: 1'b0
    };

    localparam timing_t TIMING_1280X720_60 = '{
        h_active: 12'd1280, h_fp: 12'd110, h_sync: 12'd40, h_bp: 12'd220,
        v_active: 12'd720,  v_fp: 12'd5,   v_sync: 12'd5,  v_bp: 12'd20,
        hs_pol:   1'b1,     vs_pol: 1'b1
    };

    // TMDS control-period symbols, indexed by {c1, c0}.
    localparam logic [9:0] TMDS_CTRL_00 = 10'b1101010100;
    localparam logic [9:0] TMDS_CTRL_01 = 10'b0010101011;
    localparam logic [9:0] TMDS_CTRL_10 = 10'b0101010100;
    localparam logic [9:0] TMDS_CTRL_11 = 10'b1010101011;

    function automatic logic [9:0] tmds_ctrl_code(input logic [1:0] ctrl);
        logic [9:0] code;
        case (ctrl)
            2'b00:   code = TMDS_CTRL_00;
            2'b01:   code = TMDS_CTRL_01;
            2'b10:   code = TMDS_CTRL_10;
            default: code = TMDS_CTRL_11;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/video_delay.sv
// Fixed-depth shift register for video side-band signals.
// Every stage loads RST_VAL on reset; DEPTH=0 degenerates to a wire.
//  clk    in   clock
//  rst_n  in   asynchronous reset, active low
//  d      in   WIDTH  input sample
//  q      out  WIDTH  input delayed by DEPTH clocks
module video_delay #(
    parameter int unsigned      WIDTH   = 1,
    parameter int unsigned      DEPTH   = 1,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    if (DEPTH == 0) begin : g_wire
        logic unused_clk_rst;
        assign unused_clk_rst = clk ^ rst_n;
        assign q = d;
    end else begin : g_sr
        logic [WIDTH-1:0] stage [DEPTH];

        // stage[0] is the newest sample, stage[DEPTH-1] the output.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                for (int i = 0; i < DEPTH; i++) begin
                    stage[i] <= RST_VAL;
                end
            end else begin
                stage[0] <= d;
                for (int i = 1; i < DEPTH; i++) begin
                    stage[i] <= stage[i-1];
                end
            end
        end

        assign q = stage[DEPTH-1];
    end

endmodule

// File: rtl/dvi_timing_gen.sv
// Raster timing source for a DVI transmitter. Emits pixel coordinates and a
// fetch request to the pixel source, and delays active/hsync/vsync by DLY
// clocks so they line up with the returned pixel data at the encoders.
//  clk       in   pixel clock
//  rst_n     in   asynchronous reset, active low
//  enable    in   run raster; low parks the generator at (0,0)
//  x_o       out  12  current column, valid with req_o
//  y_o       out  12  current line, valid with req_o
//  req_o     out  pixel fetch request (visible area)
//  sof_o     out  start-of-frame pulse at (0,0), request timebase
//  active_o  out  req_o delayed DLY clocks (encoder active)
//  hsync_o   out  physical hsync level, delayed DLY clocks
//  vsync_o   out  physical vsync level, delayed DLY clocks
//  ctrl_o    out  {vsync_o, hsync_o} for the blue-channel encoder
module dvi_timing_gen
    import dvi_pkg::*;
#(
    parameter int unsigned H_ACTIVE = 32'(TIMING_640X480_60.h_active),
    parameter int unsigned H_FP     = 32'(TIMING_640X480_60.h_fp),
    parameter int unsigned H_SYNC   = 32'(TIMING_640X480_60.h_sync),
    parameter int unsigned H_BP     = 32'(TIMING_640X480_60.h_bp),
    parameter int unsigned V_ACTIVE = 32'(TIMING_640X480_60.v_active),
    parameter int unsigned V_FP     = 32'(TIMING_640X480_60.v_fp),
    parameter int unsigned V_SYNC   = 32'(TIMING_640X480_60.v_sync),
    parameter int unsigned V_BP     = 32'(TIMING_640X480_60.v_bp),
    parameter logic        HS_POL   = TIMING_640X480_60.hs_pol,
    parameter logic        VS_POL   = TIMING_640X480_60.vs_pol,
    parameter int unsigned DLY      = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable,
    output logic [11:0] x_o,
    output logic [11:0] y_o,
    output logic        req_o,
    output logic        sof_o,
    output logic        active_o,
    output logic        hsync_o,
    output logic        vsync_o,
    output logic [1:0]  ctrl_o
);

    localparam int unsigned H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int unsigned HS_START = H_ACTIVE + H_FP;
    localparam int unsigned HS_END   = HS_START + H_SYNC;
    localparam int unsigned VS_START = V_ACTIVE + V_FP;
    localparam int unsigned VS_END   = VS_START + V_SYNC;
    localparam int unsigned CMP_W    = CNT_W + 1;

    // Compare in CNT_W+1 bits so segment bounds of exactly 4096 stay exact.
    localparam logic [CMP_W-1:0] H_ACT_C   = CMP_W'(H_ACTIVE);
    localparam logic [CMP_W-1:0] V_ACT_C   = CMP_W'(V_ACTIVE);
    localparam logic [CMP_W-1:0] HS_STRT_C = CMP_W'(HS_START);
    localparam logic [CMP_W-1:0] HS_END_C  = CMP_W'(HS_END);
    localparam logic [CMP_W-1:0] VS_STRT_C = CMP_W'(VS_START);
    localparam logic [CMP_W-1:0] VS_END_C  = CMP_W'(VS_END);
    localparam logic [CNT_W-1:0] H_LAST    = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST    = CNT_W'(V_TOTAL - 1);

    if (H_TOTAL > MAX_TOTAL || H_TOTAL == 0) begin : g_bad_h_total
        $error("dvi_timing_gen: H_TOTAL must be 1..4096");
    end
    if (V_TOTAL > MAX_TOTAL || V_TOTAL == 0) begin : g_bad_v_total
        $error("dvi_timing_gen: V_TOTAL must be 1..4096");
    end
    if (DLY > MAX_DLY) begin : g_bad_dly
        $error("dvi_timing_gen: DLY must be 0..15");
    end

    logic [CNT_W-1:0] hcnt;
    logic [CNT_W-1:0] vcnt;
    logic [CMP_W-1:0] hcnt_x;
    logic [CMP_W-1:0] vcnt_x;
    logic             h_last;
    logic             v_last;
    logic             vis;
    logic             hs_asrt;
    logic             vs_asrt;
    logic             hs_req;
    logic             vs_req;
    logic [2:0]       dly_q;

    assign hcnt_x  = {1'b0, hcnt};
    assign vcnt_x  = {1'b0, vcnt};
    assign h_last  = (hcnt == H_LAST);
    assign v_last  = (vcnt == V_LAST);
    assign vis     = (hcnt_x < H_ACT_C) && (vcnt_x < V_ACT_C);
    assign hs_asrt = (hcnt_x >= HS_STRT_C) && (hcnt_x < HS_END_C);
    assign vs_asrt = (vcnt_x >= VS_STRT_C) && (vcnt_x < VS_END_C);

    // Raster counters; vcnt only moves on the line wrap so vsync is whole lines.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hcnt <= '0;
            vcnt <= '0;
        end else if (!enable) begin
            hcnt <= '0;
            vcnt <= '0;
        end else if (h_last) begin
            hcnt <= '0;
            vcnt <= v_last ? '0 : vcnt + CNT_W'(1);
        end else begin
            hcnt <= hcnt + CNT_W'(1);
        end
    end

    // Request stage: coordinates, fetch request and undelayed physical syncs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_o    <= '0;
            y_o    <= '0;
            req_o  <= 1'b0;
            sof_o  <= 1'b0;
            hs_req <= ~HS_POL;
            vs_req <= ~VS_POL;
        end else if (!enable) begin
            x_o    <= '0;
            y_o    <= '0;
            req_o  <= 1'b0;
            sof_o  <= 1'b0;
            hs_req <= ~HS_POL;
            vs_req <= ~VS_POL;
        end else begin
            x_o    <= hcnt;
            y_o    <= vcnt;
            req_o  <= vis;
            sof_o  <= (hcnt == '0) && (vcnt == '0);
            hs_req <= hs_asrt ? HS_POL : ~HS_POL;
            vs_req <= vs_asrt ? VS_POL : ~VS_POL;
        end
    end

    // Align active/syncs with pixel data; keeps shifting while disabled so
    // in-flight cycles drain out before the line goes idle.
    video_delay #(
        .WIDTH   (3),
        .DEPTH   (DLY),
        .RST_VAL ({1'b0, ~VS_POL, ~HS_POL})
    ) u_delay (
        .clk   (clk),
        .rst_n (rst_n),
        .d     ({req_o, vs_req, hs_req}),
        .q     (dly_q)
    );

    assign active_o = dly_q[2];
    assign vsync_o  = dly_q[1];
    assign hsync_o  = dly_q[0];
    assign ctrl_o   = {dly_q[1], dly_q[0]};

endmodule

// File: tb/tb_dvi_timing_gen.sv
// Bench for dvi_timing_gen: four instances (640x480 with DLY=2 and DLY=0,
// a tiny positive-polarity mode, a medium mode with DLY=15) run against a
// per-instance raster model through a scoreboard, plus directed checks.
module tb_dvi_timing_gen;

    localparam int N = 4;

    typedef struct {
        int ha, hf, hs, hb;
        int va, vf, vs, vb;
        bit hp, vp;
        int dly;
    } cfg_t;

    typedef struct packed {
        logic [11:0] x;
        logic [11:0] y;
        logic        req;
        logic        sof;
        logic        hs;
        logic        vs;
    } exp_t;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic [N-1:0]         en;
    logic [N-1:0][11:0]   x_w;
    logic [N-1:0][11:0]   y_w;
    logic [N-1:0]         req_w, sof_w, act_w, hs_w, vs_w;
    logic [N-1:0][1:0]    ctrl_w;

    int   n_checks = 0;
    int   n_errors = 0;
    int   mh [N];
    int   mv [N];
    exp_t hist [N][16];
    exp_t cur  [N];
    exp_t sb_q [$];

    always #5 clk = ~clk;

    dvi_timing_gen #(.DLY(2)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .enable(en[0]), .x_o(x_w[0]), .y_o(y_w[0]),
        .req_o(req_w[0]), .sof_o(sof_w[0]), .active_o(act_w[0]),
        .hsync_o(hs_w[0]), .vsync_o(vs_w[0]), .ctrl_o(ctrl_w[0]));

    dvi_timing_gen #(.DLY(0)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .enable(en[1]), .x_o(x_w[1]), .y_o(y_w[1]),
        .req_o(req_w[1]), .sof_o(sof_w[1]), .active_o(act_w[1]),
        .hsync_o(hs_w[1]), .vsync_o(vs_w[1]), .ctrl_o(ctrl_w[1]));

    dvi_timing_gen #(
        .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
        .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .HS_POL(1'b1), .VS_POL(1'b1), .DLY(0)
    ) u_dut2 (
        .clk(clk), .rst_n(rst_n), .enable(en[2]), .x_o(x_w[2]), .y_o(y_w[2]),
        .req_o(req_w[2]), .sof_o(sof_w[2]), .active_o(act_w[2]),
        .hsync_o(hs_w[2]), .vsync_o(vs_w[2]), .ctrl_o(ctrl_w[2]));

    dvi_timing_gen #(
        .H_ACTIVE(20), .H_FP(4), .H_SYNC(6), .H_BP(2),
        .V_ACTIVE(10), .V_FP(2), .V_SYNC(3), .V_BP(2),
        .HS_POL(1'b0), .VS_POL(1'b0), .DLY(15)
    ) u_dut3 (
        .clk(clk), .rst_n(rst_n), .enable(en[3]), .x_o(x_w[3]), .y_o(y_w[3]),
        .req_o(req_w[3]), .sof_o(sof_w[3]), .active_o(act_w[3]),
        .hsync_o(hs_w[3]), .vsync_o(vs_w[3]), .ctrl_o(ctrl_w[3]));

    function automatic cfg_t cfg_of(input int i);
        cfg_t c;
        case (i)
            0:       c = '{640, 16, 96, 48, 480, 10, 2, 33, 1'b0, 1'b0, 2};
            1:       c = '{640, 16, 96, 48, 480, 10, 2, 33, 1'b0, 1'b0, 0};
            2:       c = '{4, 1, 2, 1, 3, 1, 1, 1, 1'b1, 1'b1, 0};
            default: c = '{20, 4, 6, 2, 10, 2, 3, 2, 1'b0, 1'b0, 15};
        endcase
        return c;
    endfunction

    function automatic exp_t idle_of(input int i);
        cfg_t c;
        exp_t r;
        c = cfg_of(i);
        r = '0;
        r.hs = ~c.hp;
        r.vs = ~c.vp;
        return r;
    endfunction

    function automatic exp_t ref_out(input int i, input int h, input int v, input logic e);
        cfg_t c;
        exp_t r;
        c = cfg_of(i);
        if (!e) return idle_of(i);
        r.x   = 12'(h);
        r.y   = 12'(v);
        r.req = (h < c.ha) && (v < c.va);
        r.sof = (h == 0) && (v == 0);
        r.hs  = (h >= c.ha + c.hf && h < c.ha + c.hf + c.hs) ? c.hp : ~c.hp;
        r.vs  = (v >= c.va + c.vf && v < c.va + c.vf + c.vs) ? c.vp : ~c.vp;
        return r;
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Model: one expected request-stage entry per instance per clock.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sb_q.delete();
            for (int i = 0; i < N; i++) begin
                mh[i]  = 0;
                mv[i]  = 0;
                cur[i] = idle_of(i);
                for (int k = 0; k < 16; k++) hist[i][k] = idle_of(i);
            end
        end else begin
            for (int i = 0; i < N; i++) begin
                cfg_t c;
                exp_t e;
                c = cfg_of(i);
                e = ref_out(i, mh[i], mv[i], en[i]);
                sb_q.push_back(e);
                for (int k = 15; k > 0; k--) hist[i][k] = hist[i][k-1];
                hist[i][0] = e;
                if (!en[i]) begin
                    mh[i] = 0;
                    mv[i] = 0;
                end else begin
                    mh[i]++;
                    if (mh[i] == c.ha + c.hf + c.hs + c.hb) begin
                        mh[i] = 0;
                        mv[i]++;
                        if (mv[i] == c.va + c.vf + c.vs + c.vb) mv[i] = 0;
                    end
                end
            end
        end
    end

    // Scoreboard compare, away from the active edge.
    always @(negedge clk) begin
        if (rst_n) begin
            for (int i = 0; i < N; i++) begin
                int   d;
                exp_t h;
                if (sb_q.size() > 0) cur[i] = sb_q.pop_front();
                d = cfg_of(i).dly;
                h = hist[i][d];
                check($sformatf("sb_req%0d", i),
                      {x_w[i], y_w[i], req_w[i], sof_w[i]},
                      {cur[i].x, cur[i].y, cur[i].req, cur[i].sof});
                check($sformatf("sb_dly%0d", i),
                      {act_w[i], hs_w[i], vs_w[i], ctrl_w[i]},
                      {h.req, h.hs, h.vs, h.vs, h.hs});
            end
        end
    end

    // One 640x480 line on the DLY=0 instance starting at x=0.
    task automatic check_line();
        int reqs, lows, first, last, bad;
        logic [11:0] px;
        reqs = 0; lows = 0; first = -1; last = -1; bad = 0;
        check("line_start_x", x_w[1], 0);
        px = x_w[1];
        for (int k = 0; k < 800; k++) begin
            if (req_w[1]) reqs++;
            if (!hs_w[1]) begin
                lows++;
                if (first < 0) first = int'(x_w[1]);
                last = int'(x_w[1]);
            end
            @(negedge clk);
            if (!((x_w[1] == px + 12'd1) || (px == 12'd799 && x_w[1] == 12'd0))) bad++;
            px = x_w[1];
        end
        check("line_req_cnt", reqs, 640);
        check("line_hs_low_cnt", lows, 96);
        check("line_hs_first", first, 656);
        check("line_hs_last", last, 751);
        check("line_x_step", bad, 0);
        check("line_wrap_x", x_w[1], 0);
    endtask

    initial begin
        bit found;
        int cnt, hs_hi, vs_hi, sofs, bad_hs, bad_vs;

        rst_n = 1'b0;
        en    = '0;
        repeat (3) @(negedge clk);
        check("rst_req0", {x_w[0], y_w[0], req_w[0], sof_w[0]}, 0);
        check("rst_sync0", {act_w[0], hs_w[0], vs_w[0], ctrl_w[0]}, 5'b01111);
        check("rst_sync2", {act_w[2], hs_w[2], vs_w[2], ctrl_w[2]}, 5'b00000);

        // Scenario 1: first edge after release emits (0,0) with sof.
        en    = '1;
        rst_n = 1'b1;
        @(negedge clk);
        check("first_sof", {sof_w[0], req_w[0], x_w[0], y_w[0]}, {2'b11, 24'd0});
        check_line();

        // Scenario 4: drop enable at (300,5) on the DLY=2 instance.
        found = 0;
        for (int k = 0; k < 6000 && !found; k++) begin
            @(negedge clk);
            if (x_w[0] == 12'd300 && y_w[0] == 12'd5) found = 1;
        end
        check("wait_300_5", found, 1);
        en[0] = 1'b0;
        @(negedge clk);
        check("dis_req", {req_w[0], sof_w[0], x_w[0], y_w[0]}, 0);
        check("dis_act_d1", act_w[0], 1);
        @(negedge clk);
        check("dis_act_d2", act_w[0], 1);
        @(negedge clk);
        check("dis_act_fall", act_w[0], 0);
        repeat (10) @(negedge clk);
        en[0] = 1'b1;
        @(negedge clk);
        check("reen_sof", {sof_w[0], req_w[0], x_w[0], y_w[0]}, {2'b11, 24'd0});

        // Scenario 5: async reset in the middle of hsync.
        found = 0;
        for (int k = 0; k < 1000 && !found; k++) begin
            @(negedge clk);
            if (x_w[0] == 12'd700) found = 1;
        end
        check("wait_x700", found, 1);
        check("pre_rst_hs", hs_w[0], 0);
        #2 rst_n = 1'b0;
        #1;
        check("arst_req0", {x_w[0], y_w[0], req_w[0], sof_w[0]}, 0);
        check("arst_sync0", {act_w[0], hs_w[0], vs_w[0], ctrl_w[0]}, 5'b01111);
        check("arst_sync2", {act_w[2], hs_w[2], vs_w[2]}, 3'b000);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rerst_sof", {sof_w[0], req_w[0], x_w[0], y_w[0]}, {2'b11, 24'd0});
        check_line();

        // Scenario 6: tiny mode, two frames from sof.
        found = 0;
        for (int k = 0; k < 100 && !found; k++) begin
            if (sof_w[2]) found = 1;
            else @(negedge clk);
        end
        check("tiny_wait_sof", found, 1);
        hs_hi = 0; vs_hi = 0; sofs = 0; bad_hs = 0; bad_vs = 0;
        for (int k = 0; k < 96; k++) begin
            if (hs_w[2]) hs_hi++;
            if (vs_w[2]) vs_hi++;
            if (sof_w[2]) sofs++;
            if (hs_w[2] != (x_w[2] == 12'd5 || x_w[2] == 12'd6)) bad_hs++;
            if (vs_w[2] != (y_w[2] == 12'd4)) bad_vs++;
            @(negedge clk);
        end
        check("tiny_hs_cnt", hs_hi, 24);
        check("tiny_vs_cnt", vs_hi, 16);
        check("tiny_sof_cnt", sofs, 2);
        check("tiny_hs_pos", bad_hs, 0);
        check("tiny_vs_pos", bad_vs, 0);

        // Medium mode: frame period between sof pulses.
        found = 0;
        for (int k = 0; k < 600 && !found; k++) begin
            @(negedge clk);
            if (sof_w[3]) found = 1;
        end
        check("mid_wait_sof", found, 1);
        cnt = 0;
        found = 0;
        for (int k = 0; k < 600 && !found; k++) begin
            @(negedge clk);
            cnt++;
            if (sof_w[3]) found = 1;
        end
        check("mid_sof_period", cnt, 544);

        repeat (20) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
